// File: rtl/bus_responder.sv
// bus_responder: memory-side responder for the cpu6502 bus (RAM, I/O page, byte-stream loader)
// Ports: clk_in, reset        - clock, synchronous active-high reset
//        bus_address, bus_wdata, bus_read_write, bus_rdata - core bus; bus_rdata is combinational
//        cpu_reset_out        - holds the core in reset while a load is in progress
//        load_start, load_valid, load_data, load_last, load_ready - loader byte stream
//        gpio_out, gpio_in    - output port register, asynchronous input port
module bus_responder #(
   parameter int          ADDR_WIDTH = 11,
   parameter logic [15:0] IO_BASE    = 16'hFF00,
   parameter logic [7:0]  HOLD_BYTE  = 8'hEA
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic [15:0] bus_address,
   input  logic [7:0]  bus_wdata,
   input  logic        bus_read_write,
   output logic [7:0]  bus_rdata,
   output logic        cpu_reset_out,
   input  logic        load_start,
   input  logic        load_valid,
   input  logic [7:0]  load_data,
   input  logic        load_last,
   output logic        load_ready,
   output logic [7:0]  gpio_out,
   input  logic [7:0]  gpio_in
);
   typedef enum logic [1:0] {IDLE, LOADING, RELEASE} state_t;
   state_t                state;
   logic [7:0]            mem [2**ADDR_WIDTH];
   logic [ADDR_WIDTH-1:0] ptr;
   logic [15:0]           timer;
   logic [7:0]            timer_hi_shadow, io_rdata, sync1, sync2;
   logic [1:0]            status;
   logic [3:0]            off;
   logic                  in_ram, in_io, bus_we, io_we, ld_we;
   always_comb begin
      in_ram = bus_address[15:ADDR_WIDTH] == '0;
      in_io = bus_address[15:4] == IO_BASE[15:4];
      off = bus_address[3:0];
      bus_we = state == IDLE && !bus_read_write && !reset;
      io_we = bus_we && in_io;
      ld_we = state == LOADING && load_valid && !reset;
      io_rdata = off == 4'd0 ? gpio_out :
                 off == 4'd1 ? sync2 :
                 off == 4'd2 ? timer[7:0] :
                 off == 4'd3 ? timer_hi_shadow :
                 off == 4'd4 ? {6'd0, status} : 8'h00;
      bus_rdata = cpu_reset_out ? HOLD_BYTE :
                  in_ram        ? mem[bus_address[ADDR_WIDTH-1:0]] :
                  in_io         ? io_rdata : 8'hFF;
   end
   // Loader and bus never write in the same cycle: the bus only writes in IDLE.
   always_ff @(posedge clk_in) begin
      if (ld_we) mem[ptr] <= load_data;
      else if (bus_we && in_ram) mem[bus_address[ADDR_WIDTH-1:0]] <= bus_wdata;
   end
   always_ff @(posedge clk_in) begin
      if (reset) begin
         gpio_out <= '0;
         timer <= '0;
         timer_hi_shadow <= '0;
         status <= '0;
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= gpio_in;
         sync2 <= sync1;
         timer <= io_we && off == 4'd2 ? 16'd0 : timer + 16'd1;
         if (io_we && off == 4'd0) gpio_out <= bus_wdata;
         // Latching the high byte on a LO read gives the core a coherent 16-bit snapshot.
         if (state == IDLE && bus_read_write && in_io && off == 4'd2) timer_hi_shadow <= timer[15:8];
         // Sticky flags: a new event wins over a write-one-to-clear in the same cycle.
         status[0] <= (&timer) | (status[0] & ~(io_we && off == 4'd4 && bus_wdata[0]));
         status[1] <= (ld_we && &ptr) | (status[1] & ~(io_we && off == 4'd4 && bus_wdata[1]));
      end
   end
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state <= IDLE;
         cpu_reset_out <= 1'b0;
         load_ready <= 1'b0;
         ptr <= '0;
      end else if (state == IDLE) begin
         if (load_start) begin
            state <= LOADING;
            cpu_reset_out <= 1'b1;
            load_ready <= 1'b1;
         end
      end else if (state == LOADING) begin
         if (load_valid) begin
            ptr <= ptr + 1'b1;
            if (load_last) begin
               state <= RELEASE;
               load_ready <= 1'b0;
            end
         end
      end else begin
         state <= IDLE;
         cpu_reset_out <= 1'b0;
         ptr <= '0;
      end
   end
endmodule

// File: tb/tb_bus_responder.sv
// tb_bus_responder: randomized self-checking bench for bus_responder (default and ADDR_WIDTH=8 instances)
module tb_bus_responder;
   logic        clk_in = 1'b0, reset = 1'b1;
   logic [15:0] bus_address = '0;
   logic [7:0]  bus_wdata = '0, load_data = '0, gpio_in = '0;
   logic        bus_read_write = 1'b1, load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
   logic [7:0]  bus_rdata, gpio_out, bus_rdata8, gpio_out8;
   logic        cpu_reset_out, load_ready, cpu_reset_out8, load_ready8;
   int          n_checks = 0, n_fail = 0;
   logic [7:0]  exp_mem [2048];
   logic [7:0]  exp_mem8 [256];
   logic [7:0]  bytes_q [$];

   always #5 clk_in = ~clk_in;

   bus_responder dut (
      .clk_in(clk_in), .reset(reset), .bus_address(bus_address), .bus_wdata(bus_wdata),
      .bus_read_write(bus_read_write), .bus_rdata(bus_rdata), .cpu_reset_out(cpu_reset_out),
      .load_start(load_start), .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
      .load_ready(load_ready), .gpio_out(gpio_out), .gpio_in(gpio_in));

   bus_responder #(.ADDR_WIDTH(8)) dut8 (
      .clk_in(clk_in), .reset(reset), .bus_address(bus_address), .bus_wdata(bus_wdata),
      .bus_read_write(bus_read_write), .bus_rdata(bus_rdata8), .cpu_reset_out(cpu_reset_out8),
      .load_start(load_start), .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
      .load_ready(load_ready8), .gpio_out(gpio_out8), .gpio_in(gpio_in));

   task automatic cyc(input int n = 1);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic rd(input logic [15:0] a);
      bus_address = a;
      bus_read_write = 1'b1;
      @(negedge clk_in);
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      bus_address = a;
      bus_wdata = d;
      bus_read_write = 1'b0;
      cyc();
      bus_read_write = 1'b1;
      if (a < 16'h0800) exp_mem[a[10:0]] = d;
      if (a < 16'h0100) exp_mem8[a[7:0]] = d;
   endtask

   task automatic send_load();
      int p = 0;
      load_start = 1'b1;
      cyc();
      load_start = 1'b0;
      foreach (bytes_q[i]) begin
         load_valid = 1'b0;
         if ($urandom_range(0, 3) == 0) cyc();
         load_valid = 1'b1;
         load_data = bytes_q[i];
         load_last = i == bytes_q.size() - 1;
         exp_mem[p % 2048] = bytes_q[i];
         exp_mem8[p % 256] = bytes_q[i];
         p++;
         cyc();
      end
      load_valid = 1'b0;
      load_last = 1'b0;
      cyc();
   endtask

   task automatic test_reset();
      cyc(2);
      n_checks++; if (cpu_reset_out !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_reset got %b exp 0", cpu_reset_out); end
      n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL reset_load_ready got %b exp 0", load_ready); end
      n_checks++; if (gpio_out !== 8'h00) begin n_fail++; $display("FAIL reset_gpio_out got %h exp 00", gpio_out); end
      reset = 1'b0;
      rd(16'hFF02);
      n_checks++; if (bus_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_timer got %h exp 00", bus_rdata); end
      cyc();
      rd(16'hFF04);
      n_checks++; if (bus_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_status got %h exp 00", bus_rdata); end
      cyc();
      rd(16'hFF01);
      n_checks++; if (bus_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_port_in got %h exp 00", bus_rdata); end
      cyc();
   endtask

   task automatic test_ram();
      logic [15:0] addrs [8];
      wr(16'h0000, 8'hA9);
      rd(16'h0000);
      n_checks++; if (bus_rdata !== 8'hA9) begin n_fail++; $display("FAIL ram_preload got %h exp a9", bus_rdata); end
      cyc();
      wr(16'h0010, 8'h5A);
      rd(16'h0010);
      n_checks++; if (bus_rdata !== 8'h5A) begin n_fail++; $display("FAIL ram_write_read got %h exp 5a", bus_rdata); end
      cyc();
      wr(16'h07FF, 8'hC3);
      foreach (addrs[i]) begin
         addrs[i] = 16'($urandom_range(32'h20, 32'h7FE));
         wr(addrs[i], 8'($urandom));
      end
      foreach (addrs[i]) begin
         rd(addrs[i]);
         n_checks++; if (bus_rdata !== exp_mem[addrs[i][10:0]]) begin n_fail++; $display("FAIL ram_random[%0h] got %h exp %h", addrs[i], bus_rdata, exp_mem[addrs[i][10:0]]); end
         cyc();
      end
      rd(16'h07FF);
      n_checks++; if (bus_rdata !== 8'hC3) begin n_fail++; $display("FAIL ram_top got %h exp c3", bus_rdata); end
      cyc();
      rd(16'h0800);
      n_checks++; if (bus_rdata !== 8'hFF) begin n_fail++; $display("FAIL above_ram got %h exp ff", bus_rdata); end
      cyc();
      rd(16'h0100);
      n_checks++; if (bus_rdata8 !== 8'hFF) begin n_fail++; $display("FAIL above_ram8 got %h exp ff", bus_rdata8); end
      cyc();
   endtask

   task automatic test_load();
      logic [7:0] b [3] = '{8'hA9, 8'h42, 8'hEA};
      load_valid = 1'b1;
      load_data = 8'h99;
      rd(16'h0000);
      cyc();
      load_valid = 1'b0;
      rd(16'h0000);
      n_checks++; if (bus_rdata !== exp_mem[0]) begin n_fail++; $display("FAIL idle_valid_ignored got %h exp %h", bus_rdata, exp_mem[0]); end
      n_checks++; if (cpu_reset_out !== 1'b0) begin n_fail++; $display("FAIL idle_valid_no_hold got %b exp 0", cpu_reset_out); end
      cyc();
      load_start = 1'b1;
      @(negedge clk_in);
      n_checks++; if (cpu_reset_out !== 1'b0) begin n_fail++; $display("FAIL start_cycle_hold got %b exp 0", cpu_reset_out); end
      cyc();
      load_start = 1'b0;
      bus_address = 16'hFF00;
      bus_wdata = 8'h77;
      bus_read_write = 1'b0;
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1;
         load_data = b[i];
         load_last = i == 2;
         exp_mem[i] = b[i];
         exp_mem8[i] = b[i];
         @(negedge clk_in);
         n_checks++; if (cpu_reset_out !== 1'b1) begin n_fail++; $display("FAIL load_hold[%0d] got %b exp 1", i, cpu_reset_out); end
         n_checks++; if (load_ready !== 1'b1 || load_ready8 !== 1'b1) begin n_fail++; $display("FAIL load_ready[%0d] got %b/%b exp 1", i, load_ready, load_ready8); end
         n_checks++; if (bus_rdata !== 8'hEA) begin n_fail++; $display("FAIL hold_byte[%0d] got %h exp ea", i, bus_rdata); end
         cyc();
      end
      load_valid = 1'b0;
      load_last = 1'b0;
      @(negedge clk_in);
      n_checks++; if (cpu_reset_out !== 1'b1) begin n_fail++; $display("FAIL release_hold got %b exp 1", cpu_reset_out); end
      n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL release_ready got %b exp 0", load_ready); end
      cyc();
      bus_read_write = 1'b1;
      @(negedge clk_in);
      n_checks++; if (cpu_reset_out !== 1'b0) begin n_fail++; $display("FAIL idle_after_load got %b exp 0", cpu_reset_out); end
      n_checks++; if (gpio_out !== 8'h00) begin n_fail++; $display("FAIL held_write_ignored got %h exp 00", gpio_out); end
      cyc();
      for (int i = 0; i < 3; i++) begin
         rd(16'(i));
         n_checks++; if (bus_rdata !== b[i]) begin n_fail++; $display("FAIL load_fixed[%0d] got %h exp %h", i, bus_rdata, b[i]); end
         cyc();
      end
      bytes_q.delete();
      repeat ($urandom_range(4, 12)) bytes_q.push_back(8'($urandom));
      send_load();
      foreach (bytes_q[i]) begin
         rd(16'(i));
         n_checks++; if (bus_rdata !== exp_mem[i] || bus_rdata8 !== exp_mem8[i]) begin n_fail++; $display("FAIL load_random[%0d] got %h/%h exp %h", i, bus_rdata, bus_rdata8, exp_mem[i]); end
         cyc();
      end
   endtask

   task automatic test_gpio();
      logic [7:0] v;
      bus_address = 16'hFF00;
      bus_wdata = 8'h3C;
      bus_read_write = 1'b0;
      @(negedge clk_in);
      n_checks++; if (gpio_out !== 8'h00) begin n_fail++; $display("FAIL gpio_before_edge got %h exp 00", gpio_out); end
      cyc();
      bus_read_write = 1'b1;
      @(negedge clk_in);
      n_checks++; if (gpio_out !== 8'h3C || gpio_out8 !== 8'h3C) begin n_fail++; $display("FAIL gpio_out got %h/%h exp 3c", gpio_out, gpio_out8); end
      n_checks++; if (bus_rdata !== 8'h3C) begin n_fail++; $display("FAIL gpio_readback got %h exp 3c", bus_rdata); end
      cyc();
      gpio_in = 8'h81;
      rd(16'hFF01);
      n_checks++; if (bus_rdata !== 8'h00) begin n_fail++; $display("FAIL port_in_lat0 got %h exp 00", bus_rdata); end
      cyc();
      @(negedge clk_in);
      n_checks++; if (bus_rdata !== 8'h00) begin n_fail++; $display("FAIL port_in_lat1 got %h exp 00", bus_rdata); end
      cyc();
      @(negedge clk_in);
      n_checks++; if (bus_rdata !== 8'h81) begin n_fail++; $display("FAIL port_in_lat2 got %h exp 81", bus_rdata); end
      cyc();
      repeat (4) begin
         v = 8'($urandom);
         gpio_in = v;
         cyc(2);
         rd(16'hFF01);
         n_checks++; if (bus_rdata !== v) begin n_fail++; $display("FAIL port_in_rand got %h exp %h", bus_rdata, v); end
         cyc();
         v = 8'($urandom);
         wr(16'hFF00, v);
         @(negedge clk_in);
         n_checks++; if (gpio_out !== v) begin n_fail++; $display("FAIL gpio_rand got %h exp %h", gpio_out, v); end
         cyc();
      end
      rd(16'hFF10);
      n_checks++; if (bus_rdata !== 8'hFF) begin n_fail++; $display("FAIL unmapped_ff10 got %h exp ff", bus_rdata); end
      cyc();
      wr(16'hFF07, 8'hAB);
      rd(16'hFF00 + 16'($urandom_range(5, 15)));
      n_checks++; if (bus_rdata !== 8'h00) begin n_fail++; $display("FAIL io_reserved got %h exp 00", bus_rdata); end
      cyc();
   endtask

   task automatic test_timer();
      logic [15:0] w [2];
      w[0] = 16'h12FF;
      w[1] = 16'($urandom_range(256, 4660));
      foreach (w[i]) begin
         wr(16'hFF02, 8'($urandom));
         bus_address = 16'h0000;
         cyc(int'(w[i]));
         rd(16'hFF02);
         n_checks++; if (bus_rdata !== w[i][7:0]) begin n_fail++; $display("FAIL timer_lo got %h exp %h", bus_rdata, w[i][7:0]); end
         cyc();
         rd(16'hFF03);
         n_checks++; if (bus_rdata !== w[i][15:8]) begin n_fail++; $display("FAIL timer_hi got %h exp %h", bus_rdata, w[i][15:8]); end
         cyc();
      end
      wr(16'hFF02, 8'h00);
      bus_address = 16'h0000;
      cyc(65535);
      rd(16'hFF04);
      n_checks++; if (bus_rdata !== 8'h00) begin n_fail++; $display("FAIL status_prewrap got %h exp 00", bus_rdata); end
      cyc();
      @(negedge clk_in);
      n_checks++; if (bus_rdata !== 8'h01 || bus_rdata8 !== 8'h01) begin n_fail++; $display("FAIL status_wrap got %h/%h exp 01", bus_rdata, bus_rdata8); end
      cyc();
      wr(16'hFF04, 8'h02);
      rd(16'hFF04);
      n_checks++; if (bus_rdata !== 8'h01) begin n_fail++; $display("FAIL status_clr_other got %h exp 01", bus_rdata); end
      cyc();
      wr(16'hFF04, 8'h01);
      rd(16'hFF04);
      n_checks++; if (bus_rdata !== 8'h00) begin n_fail++; $display("FAIL status_clr got %h exp 00", bus_rdata); end
      cyc();
   endtask

   task automatic test_overflow();
      logic [7:0] exp_st8;
      bytes_q.delete();
      repeat (257) bytes_q.push_back(8'($urandom));
      exp_st8 = bytes_q.size() > 256 ? 8'h02 : 8'h00;
      send_load();
      rd(16'h0000);
      n_checks++; if (bus_rdata8 !== exp_mem8[0]) begin n_fail++; $display("FAIL ovf_wrap_byte got %h exp %h", bus_rdata8, exp_mem8[0]); end
      n_checks++; if (bus_rdata !== exp_mem[0]) begin n_fail++; $display("FAIL wide_first_byte got %h exp %h", bus_rdata, exp_mem[0]); end
      cyc();
      rd(16'h00FF);
      n_checks++; if (bus_rdata8 !== exp_mem8[255]) begin n_fail++; $display("FAIL ovf_top_byte got %h exp %h", bus_rdata8, exp_mem8[255]); end
      cyc();
      rd(16'h0100);
      n_checks++; if (bus_rdata !== exp_mem[256]) begin n_fail++; $display("FAIL wide_byte256 got %h exp %h", bus_rdata, exp_mem[256]); end
      cyc();
      rd(16'hFF04);
      n_checks++; if (bus_rdata8 !== exp_st8) begin n_fail++; $display("FAIL ovf_status got %h exp %h", bus_rdata8, exp_st8); end
      n_checks++; if (bus_rdata !== 8'h00) begin n_fail++; $display("FAIL wide_status got %h exp 00", bus_rdata); end
      cyc();
      wr(16'hFF04, 8'h02);
      rd(16'hFF04);
      n_checks++; if (bus_rdata8 !== 8'h00) begin n_fail++; $display("FAIL ovf_status_clr got %h exp 00", bus_rdata8); end
      cyc();
   endtask

   task automatic test_mid_load_reset();
      logic [7:0] b0, b1;
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      load_start = 1'b1;
      cyc();
      load_start = 1'b0;
      load_valid = 1'b1;
      load_data = b0;
      cyc();
      load_data = b1;
      cyc();
      exp_mem[0] = b0;
      exp_mem[1] = b1;
      load_valid = 1'b0;
      reset = 1'b1;
      cyc();
      n_checks++; if (cpu_reset_out !== 1'b0 || cpu_reset_out8 !== 1'b0) begin n_fail++; $display("FAIL midreset_release got %b/%b exp 0", cpu_reset_out, cpu_reset_out8); end
      n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_ready got %b exp 0", load_ready); end
      n_checks++; if (gpio_out !== 8'h00) begin n_fail++; $display("FAIL midreset_gpio got %h exp 00", gpio_out); end
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rd(16'(i));
         n_checks++; if (bus_rdata !== exp_mem[i]) begin n_fail++; $display("FAIL midreset_kept[%0d] got %h exp %h", i, bus_rdata, exp_mem[i]); end
         cyc();
      end
      bytes_q.delete();
      bytes_q.push_back(8'($urandom));
      send_load();
      for (int i = 0; i < 2; i++) begin
         rd(16'(i));
         n_checks++; if (bus_rdata !== exp_mem[i]) begin n_fail++; $display("FAIL reload_ptr0[%0d] got %h exp %h", i, bus_rdata, exp_mem[i]); end
         cyc();
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_ram();
      test_load();
      test_gpio();
      test_timer();
      test_overflow();
      test_mid_load_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
